// File: rtl/key_event_scheduler.sv
// Two-source key event scheduler: per-source edge detect and FIFO,
// round-robin sharing of one valid/accept output channel.
module key_event_scheduler #(
  parameter  int DEPTH = 4,
  parameter  int CW    = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int NW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] a_code,
  input  logic          a_ready,
  input  logic [CW-1:0] b_code,
  input  logic          b_ready,
  output logic [CW-1:0] out_code,
  output logic          out_src,
  output logic          out_valid,
  input  logic          out_accept,
  output logic          a_drop,
  output logic          b_drop,
  output logic [NW-1:0] a_count,
  output logic [NW-1:0] b_count
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] mem_a [DEPTH];
  logic [CW-1:0] mem_b [DEPTH];
  logic [AW-1:0] wp_a, rp_a;
  logic [AW-1:0] wp_b, rp_b;
  logic [NW-1:0] cnt_a, cnt_b;
  logic prev_a, prev_b;
  logic last_grant;

  logic ev_a, ev_b;
  logic ne_a, ne_b;
  logic full_a, full_b;
  logic push_a, push_b;
  logic rej_a, rej_b;
  logic take, pop, sel_b;
  logic pop_a, pop_b;

  assign ev_a   = a_ready & ~prev_a & (a_code != '0);
  assign ev_b   = b_ready & ~prev_b & (b_code != '0);
  assign ne_a   = cnt_a != '0;
  assign ne_b   = cnt_b != '0;
  assign full_a = cnt_a == NW'(DEPTH);
  assign full_b = cnt_b == NW'(DEPTH);

  // A same-cycle pop frees a slot, so a full FIFO can still take the push.
  assign push_a = ev_a & (~full_a | pop_a);
  assign push_b = ev_b & (~full_b | pop_b);
  assign rej_a  = ev_a & ~push_a;
  assign rej_b  = ev_b & ~push_b;

  assign pop_a  = pop & ~sel_b;
  assign pop_b  = pop & sel_b;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    sel_b    = ne_b & (~ne_a | ~last_grant);
    unique case (state)
      IDLE:    take = 1'b1;
      PRESENT: take = out_accept;
      default: take = 1'b0;
    endcase
    pop = take & (ne_a | ne_b);
    unique case (state)
      IDLE:
        if (pop) state_nx = PRESENT;
      PRESENT:
        if (out_accept && !pop) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev_a     <= 1'b0;
      prev_b     <= 1'b0;
      last_grant <= 1'b1;
      out_code   <= '0;
      out_src    <= 1'b0;
      a_drop     <= 1'b0;
      b_drop     <= 1'b0;
    end else begin
      state  <= state_nx;
      prev_a <= a_ready;
      prev_b <= b_ready;
      a_drop <= rej_a;
      b_drop <= rej_b;
      if (pop) begin
        last_grant <= sel_b;
        out_src    <= sel_b;
        out_code   <= sel_b ? mem_b[rp_b]
                            : mem_a[rp_a];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_a  <= '0;
      rp_a  <= '0;
      cnt_a <= '0;
    end else begin
      if (push_a) wp_a <= wp_a + 1'b1;
      if (pop_a)  rp_a <= rp_a + 1'b1;
      unique case ({push_a, pop_a})
        2'b10:   cnt_a <= cnt_a + 1'b1;
        2'b01:   cnt_a <= cnt_a - 1'b1;
        default: cnt_a <= cnt_a;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_b  <= '0;
      rp_b  <= '0;
      cnt_b <= '0;
    end else begin
      if (push_b) wp_b <= wp_b + 1'b1;
      if (pop_b)  rp_b <= rp_b + 1'b1;
      unique case ({push_b, pop_b})
        2'b10:   cnt_b <= cnt_b + 1'b1;
        2'b01:   cnt_b <= cnt_b - 1'b1;
        default: cnt_b <= cnt_b;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_a) mem_a[wp_a] <= a_code;
    if (push_b) mem_b[wp_b] <= b_code;
  end

  assign out_valid = state == PRESENT;
  assign a_count   = cnt_a;
  assign b_count   = cnt_b;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_key_event_scheduler;

  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk;
  logic          reset;
  logic [CW-1:0] a_code, b_code;
  logic          a_ready, b_ready;
  logic [CW-1:0] out_code;
  logic          out_src, out_valid;
  logic          out_accept;
  logic          a_drop, b_drop;
  logic [2:0]    a_count, b_count;

  int vectors;
  int miscompares;

  key_event_scheduler #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_code     (a_code),
    .a_ready    (a_ready),
    .b_code     (b_code),
    .b_ready    (b_ready),
    .out_code   (out_code),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_accept (out_accept),
    .a_drop     (a_drop),
    .b_drop     (b_drop),
    .a_count    (a_count),
    .b_count    (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         m_prev_a, m_prev_b;
  bit         m_valid, m_src, m_last;
  bit         m_drop_a, m_drop_b;
  logic [7:0] m_code;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_prev_a = 0;
    m_prev_b = 0;
    m_valid  = 0;
    m_src    = 0;
    m_last   = 1;
    m_drop_a = 0;
    m_drop_b = 0;
    m_code   = '0;
  endtask

  // One clock of behaviour, from the inputs seen just before the edge.
  task automatic model_step();
    bit ea, eb, na, nb, w;
    if (reset) begin
      model_reset();
      return;
    end
    ea = a_ready && !m_prev_a && (a_code != 0);
    eb = b_ready && !m_prev_b && (b_code != 0);
    na = qa.size() > 0;
    nb = qb.size() > 0;
    m_drop_a = 0;
    m_drop_b = 0;
    if (!m_valid || out_accept) begin
      if (na || nb) begin
        w = (na && nb) ? !m_last : nb;
        if (w) m_code = qb.pop_front();
        else   m_code = qa.pop_front();
        m_src   = w;
        m_last  = w;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (ea) begin
      if (qa.size() < DEPTH) qa.push_back(a_code);
      else m_drop_a = 1;
    end
    if (eb) begin
      if (qb.size() < DEPTH) qb.push_back(b_code);
      else m_drop_b = 1;
    end
    m_prev_a = a_ready;
    m_prev_b = b_ready;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_code",  32'(out_code),  32'(m_code));
    chk("out_src",   32'(out_src),   32'(m_src));
    chk("a_drop",    32'(a_drop),    32'(m_drop_a));
    chk("b_drop",    32'(b_drop),    32'(m_drop_b));
    chk("a_count",   32'(a_count),   32'(qa.size()));
    chk("b_count",   32'(b_count),   32'(qb.size()));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    a_code      = '0;
    b_code      = '0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    out_accept  = 1'b0;
    model_reset();
    #1;
    compare_all();
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_acnt",  32'(a_count),   32'd0);

    // single key held for 10 cycles
    a_code = 8'h41;
    a_ready = 1'b1;
    out_accept = 1'b1;
    cyc();
    chk("sk_cnt1",  32'(a_count),   32'd1);
    chk("sk_v0",    32'(out_valid), 32'd0);
    cyc();
    chk("sk_valid", 32'(out_valid), 32'd1);
    chk("sk_code",  32'(out_code),  32'h41);
    chk("sk_src",   32'(out_src),   32'd0);
    cyc();
    chk("sk_once",  32'(out_valid), 32'd0);
    repeat (7) cyc();
    a_ready = 1'b0;
    cyc();

    // zero code is ignored
    b_code = 8'h00;
    b_ready = 1'b1;
    repeat (3) cyc();
    chk("zc_cnt",  32'(b_count),   32'd0);
    chk("zc_drop", 32'(b_drop),    32'd0);
    chk("zc_v",    32'(out_valid), 32'd0);
    b_ready = 1'b0;
    cyc();

    // simultaneous events from both sources
    do_reset();
    a_code = 8'h11;
    b_code = 8'h22;
    a_ready = 1'b1;
    b_ready = 1'b1;
    cyc();
    a_ready = 1'b0;
    b_ready = 1'b0;
    cyc();
    chk("sim_c0", 32'(out_code), 32'h11);
    chk("sim_s0", 32'(out_src),  32'd0);
    cyc();
    chk("sim_c1", 32'(out_code), 32'h22);
    chk("sim_s1", 32'(out_src),  32'd1);
    chk("sim_v1", 32'(out_valid), 32'd1);
    cyc();

    // backpressure, overflow drop, in-order drain
    do_reset();
    out_accept = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      a_code = 8'(i);
      a_ready = 1'b1;
      cyc();
      if (i == 5) chk("bp_full", 32'(a_count), 32'd4);
      if (i == 6) chk("bp_drop", 32'(a_drop),  32'd1);
      a_ready = 1'b0;
      cyc();
      if (i == 6) chk("bp_dclr", 32'(a_drop), 32'd0);
    end
    chk("bp_hold", 32'(out_code), 32'h01);
    out_accept = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      cyc();
      chk("bp_order", 32'(out_code), 32'(i));
    end
    cyc();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // fairness with both FIFOs loaded
    do_reset();
    out_accept = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a_code = 8'(8'hA0 + i);
      b_code = 8'(8'hB0 + i);
      a_ready = 1'b1;
      b_ready = 1'b1;
      cyc();
      a_ready = 1'b0;
      b_ready = 1'b0;
      cyc();
    end
    chk("fair_s0", 32'(out_src), 32'd0);
    out_accept = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("fair_src", 32'(out_src), 32'(i % 2));
    end
    cyc();

    // reset while events are queued and presented
    out_accept = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a_code = 8'(8'h30 + i);
      a_ready = 1'b1;
      cyc();
      a_ready = 1'b0;
      cyc();
    end
    chk("mr_pre", 32'(a_count), 32'd3);
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("mr_v", 32'(out_valid), 32'd0);
    chk("mr_c", 32'(out_code),  32'd0);
    chk("mr_n", 32'(a_count),   32'd0);
    cyc();
    reset = 1'b0;
    out_accept = 1'b1;
    cyc();
    cyc();
    chk("mr_quiet", 32'(out_valid), 32'd0);
    a_code = 8'h5A;
    a_ready = 1'b1;
    cyc();
    a_ready = 1'b0;
    cyc();
    chk("mr_new", 32'(out_code), 32'h5A);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      a_ready = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
      a_code = ($urandom_range(0, 7) == 0) ? 8'h00
             : 8'($urandom_range(1, 255));
      b_code = ($urandom_range(0, 7) == 0) ? 8'h00
             : 8'($urandom_range(1, 255));
      if ((n % 100) < 35)
        out_accept = ($urandom_range(0, 7) == 0);
      else
        out_accept = ($urandom_range(0, 3) != 0);
      if (n == 400) begin
        reset = 1'b1;
        model_reset();
        cyc();
        reset = 1'b0;
      end else begin
        cyc();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_event_scheduler.md
# key_event_scheduler

Collects key events from two independent keyboard-style sources, each presenting a code plus a level-type ready flag, and delivers them one at a time to a single consumer over a valid/accept handshake. Each source gets rising-edge event detection and its own small FIFO. A round-robin arbiter shares the one output channel between the sources. The block sits between the switch/keyboard front ends and the game/display control logic, so no keystroke is lost or duplicated when both sources are active.

## Interface
- DEPTH, 4, entries per source FIFO; power of two, at least 2
- CW, 8, key code width
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- a_code  input  CW  source A key code, valid while a_ready high
- a_ready  input  1  source A ready level (held high while key latched)
- b_code  input  CW  source B key code
- b_ready  input  1  source B ready level
- out_code  output  CW  granted key code
- out_src  output  1  0 = from A, 1 = from B
- out_valid  output  1  out_code/out_src hold a pending event
- out_accept  input  1  consumer takes the event when high with out_valid
- a_drop  output  1  one-cycle pulse: A event lost, FIFO A full
- b_drop  output  1  one-cycle pulse: B event lost, FIFO B full
- a_count  output  clog2(DEPTH)+1  entries currently in FIFO A
- b_count  output  clog2(DEPTH)+1  entries currently in FIFO B

## Operation
- Edge detect per source: register prev_x (reset 0) tracks x_ready. An event occurs in a cycle where x_ready=1 and prev_x=0. x_code is sampled in that same cycle. A level held high produces exactly one event.
- Code 0 is "no key". An event with x_code==0 is discarded: no push, no drop pulse.
- Push rule: the event is written into FIFO x if count_x<DEPTH, or if FIFO x is popped in the same cycle. Otherwise the event is discarded and x_drop pulses high for exactly one cycle.
- FIFO: circular buffer with read/write pointers mod DEPTH; count tracked explicitly. Simultaneous push and pop leaves the count unchanged.
- Output FSM, two states:
  - IDLE: out_valid=0. If any FIFO is non-empty, pop the winner, load out_code/out_src, go to PRESENT.
  - PRESENT: out_valid=1. out_code and out_src stay stable until accepted. On out_accept: if any FIFO is non-empty, pop the next winner and load it in the same cycle (back-to-back, no bubble) and stay in PRESENT; else go to IDLE.
- Arbitration: last_grant register (reset = B).
  - Only one FIFO non-empty: that FIFO wins.
  - Both non-empty: the source not equal to last_grant wins.
  - last_grant updates on every pop.
- An event pushed in cycle k is not visible to the arbiter until cycle k+1; there is no FIFO bypass.

## Timing
- Reset values: out_code=0, out_src=0, out_valid=0, a_drop=0, b_drop=0, a_count=0, b_count=0. FSM in IDLE, pointers 0, prev_a/prev_b 0, last_grant=B.
- Latency, empty block: x_ready rises and is sampled at edge k (push at k). The arbiter loads the output at edge k+1. out_valid is high from after edge k+1.
- Throughput: one event per cycle while out_accept is held high and the FIFOs are non-empty.
- out_accept with out_valid=0 is ignored.
- Both sources fire an event in the same cycle: both are pushed. The subsequent grants alternate per round-robin.
- Reset asserted mid-operation: all FIFO contents and any pending output are discarded immediately.
  - A ready level still high when reset is released produces an event on the first clock after release, because prev is 0.
- Drop pulse timing: x_drop goes high after the edge that rejected the event and clears after the next edge.

## Test plan
- Single key: a_ready rises with a_code=0x41 and is held 10 cycles, out_accept=1 → exactly one event, out_code=0x41, out_src=0, out_valid high 2 cycles after the rising sample, for 1 cycle.
- Zero code: b_ready rises with b_code=0x00 → no push, b_count stays 0, no b_drop, out_valid stays 0.
- Simultaneous: A=0x11 and B=0x22 rise in the same cycle, out_accept=1 → output 0x11 (src 0) then 0x22 (src 1) on consecutive cycles.
- Backpressure: out_accept=0 while A rises 5 times (codes 1..5) with DEPTH=4.
  - Expect 0x01 held on the output, FIFO A fills with 2..5, and the 5th push succeeds.
  - A 6th event pulses a_drop once.
  - When accept is raised, 1..5 come out in order.
- Fairness: with both FIFOs loaded with 3 entries each, output sources alternate A,B,A,B,A,B.
- Reset mid-stream: assert reset with 3 entries queued and out_valid=1 → all outputs 0 immediately, counts 0. After release, only new events appear.
